// File: rtl/sram_arbiter.sv
// Two-port controller for a 512Kx8 asynchronous SRAM: port A (read-only, priority) and port B (read/write).
// Optional macro SRAM_ARB_FAIR_EN replaces strict A priority with A/B alternation under contention.
module sram_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int ADDR_W        = 19,
    parameter int DATA_W        = 8
) (
    input  logic              sys_clk_i,
    input  logic              sys_rst_i,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_we_n,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] STROBE_LAST = 4'(ACCESS_CYCLES - 1);

    state_t     state_q;
    logic       owner_b_q;
    logic       we_q;
    logic [3:0] cnt_q;
    logic       grant_b_d;

`ifdef SRAM_ARB_FAIR_EN
    logic       fair_q;

    // Grant selection: alternate when both pending, otherwise serve whoever asks.
    always_comb begin
        grant_b_d = 1'b0;
        if (a_req && b_req) begin
            grant_b_d = fair_q;
        end else begin
            grant_b_d = b_req;
        end
    end
`else
    // Grant selection: A always wins when it is requesting.
    always_comb begin
        grant_b_d = 1'b0;
        if (a_req) begin
            grant_b_d = 1'b0;
        end else begin
            grant_b_d = b_req;
        end
    end
`endif

    // Access sequencer; the SRAM pin registers double as the latched address and write data.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q    <= ST_IDLE;
            owner_b_q  <= 1'b0;
            we_q       <= 1'b0;
            cnt_q      <= 4'd0;
            sram_addr  <= {ADDR_W{1'b0}};
            sram_we_n  <= 1'b1;
            sram_dq_o  <= {DATA_W{1'b0}};
            sram_dq_oe <= 1'b0;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            a_rdata    <= {DATA_W{1'b0}};
            b_rdata    <= {DATA_W{1'b0}};
            busy       <= 1'b0;
`ifdef SRAM_ARB_FAIR_EN
            fair_q     <= 1'b0;
`endif
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (a_req || b_req) begin
                        owner_b_q  <= grant_b_d;
                        we_q       <= grant_b_d & b_we;
                        sram_addr  <= grant_b_d ? b_addr : a_addr;
                        sram_we_n  <= 1'b1;
                        sram_dq_oe <= grant_b_d & b_we;
                        if (grant_b_d && b_we) begin
                            sram_dq_o <= b_wdata;
                        end
                        busy       <= 1'b1;
                        state_q    <= ST_SETUP;
`ifdef SRAM_ARB_FAIR_EN
                        fair_q     <= ~grant_b_d;
`endif
                    end
                end
                ST_SETUP: begin
                    sram_we_n <= ~we_q;
                    cnt_q     <= STROBE_LAST;
                    state_q   <= ST_STROBE;
                end
                ST_STROBE: begin
                    if (cnt_q == 4'd0) begin
                        sram_we_n <= 1'b1;
                        if (owner_b_q) begin
                            b_ack <= 1'b1;
                            if (!we_q) begin
                                b_rdata <= sram_dq_i;
                            end
                        end else begin
                            a_ack   <= 1'b1;
                            a_rdata <= sram_dq_i;
                        end
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_DONE: begin
                    // DQ is released one clock after WE rises to give data hold.
                    sram_dq_oe <= 1'b0;
                    busy       <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    sram_we_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                    busy       <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: behavioural SRAM model, ack scoreboard, vector table and corner sequences.
`timescale 1ns/1ps
module tb_sram_arbiter;

    localparam int AC     = 2;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;

    logic              sys_clk_i = 1'b0;
    logic              sys_rst_i = 1'b1;
    logic              a_req = 1'b0;
    logic [ADDR_W-1:0] a_addr = '0;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;
    logic              b_req = 1'b0;
    logic              b_we = 1'b0;
    logic [ADDR_W-1:0] b_addr = '0;
    logic [DATA_W-1:0] b_wdata = '0;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_we_n;
    logic [DATA_W-1:0] sram_dq_o;
    logic              sram_dq_oe;
    logic [DATA_W-1:0] sram_dq_i;
    logic              busy;

    sram_arbiter #(.ACCESS_CYCLES(AC), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .sys_clk_i(sys_clk_i), .sys_rst_i(sys_rst_i),
        .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .sram_addr(sram_addr), .sram_we_n(sram_we_n), .sram_dq_o(sram_dq_o),
        .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i), .busy(busy)
    );

    always #10 sys_clk_i = ~sys_clk_i;

    typedef struct { bit we; logic [7:0] data; } sb_t;
    typedef struct { bit port_b; bit we; logic [18:0] addr; logic [7:0] wdata; logic [7:0] exp; } vec_t;

    sb_t qa[$];
    sb_t qb[$];
    int n_vec = 0;
    int n_err = 0;
    bit abort = 1'b0;
    logic [7:0] mem [0:(1<<ADDR_W)-1];

    // Asynchronous SRAM read path; the bus reads back zero while the controller drives it.
    assign sram_dq_i = sram_dq_oe ? 8'h00 : mem[sram_addr];

    function automatic void chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge sys_clk_i);
        #1;
    endtask

    // SRAM write model: a write lands on WE rising only if the pulse was long enough and data is still driven.
    logic              prev_we_n = 1'b1;
    logic              prev_oe = 1'b0;
    int                we_low = 0;
    int                oe_high = 0;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;

    always @(negedge sys_clk_i) begin
        sb_t e;
        if (a_ack) begin
            if (qa.size() == 0) chk("a_ack_unexpected", 1, 0);
            else begin
                e = qa.pop_front();
                chk("a_rdata", a_rdata, e.data);
            end
        end
        if (b_ack) begin
            if (qb.size() == 0) chk("b_ack_unexpected", 1, 0);
            else begin
                e = qb.pop_front();
                if (!e.we) chk("b_rdata", b_rdata, e.data);
            end
        end
        if (!sram_we_n) begin
            we_low++;
            wa = sram_addr;
            wd = sram_dq_o;
        end else if (!prev_we_n) begin
            chk("we_pulse_len", we_low, AC);
            if (sram_dq_oe && we_low >= 2) mem[wa] = wd;
            we_low = 0;
        end
        if (sram_dq_oe) oe_high++;
        else if (prev_oe) begin
            if (!abort) chk("oe_window", oe_high, AC + 2);
            oe_high = 0;
        end
        if (!abort && (sram_we_n != prev_we_n)) chk("we_oe_same_edge", int'(sram_dq_oe != prev_oe), 0);
        prev_we_n = sram_we_n;
        prev_oe   = sram_dq_oe;
    end

    task automatic issue(input vec_t v);
        int n;
        bit got;
        sb_t e;
        e.we = v.we;
        e.data = v.exp;
        if (v.port_b) begin
            b_req = 1'b1; b_we = v.we; b_addr = v.addr; b_wdata = v.wdata;
            qb.push_back(e);
        end else begin
            a_req = 1'b1; a_addr = v.addr;
            qa.push_back(e);
        end
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            tick();
            n++;
            if (n == 1) chk("busy_in_setup", busy, 1);
            got = v.port_b ? b_ack : a_ack;
        end
        a_req = 1'b0;
        b_req = 1'b0;
        chk("ack_latency", got ? n : -1, AC + 2);
    endtask

    vec_t vt [7];
    int   ord [8];
    int   exp_ord;

    initial begin
        int n, first, second, na, nb, no;
        bit got, seen_max;
        sb_t e;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            mem[19'h00100 + i] = 8'(8'h10 + i);
            mem[19'h00200 + i] = 8'(8'h20 + i);
        end
        mem[19'h00555] = 8'h11;

        // Reset and idle
        sys_rst_i = 1'b1;
        repeat (3) tick();
        sys_rst_i = 1'b0;
        tick();
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_oe", sram_dq_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_a_ack", a_ack, 0);
        chk("rst_b_ack", b_ack, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_b_rdata", b_rdata, 0);

        // Vector table: {port_b, we, addr, wdata, expected rdata}
        vt[0] = '{1'b1, 1'b1, 19'h12345, 8'hA5, 8'h00};
        vt[1] = '{1'b0, 1'b0, 19'h12345, 8'h00, 8'hA5};
        vt[2] = '{1'b1, 1'b1, 19'h00000, 8'h3C, 8'h00};
        vt[3] = '{1'b1, 1'b1, 19'h7FFFF, 8'hC3, 8'h00};
        vt[4] = '{1'b1, 1'b0, 19'h7FFFF, 8'h00, 8'hC3};
        vt[5] = '{1'b0, 1'b0, 19'h00000, 8'h00, 8'h3C};
        vt[6] = '{1'b1, 1'b0, 19'h12345, 8'h00, 8'hA5};
        for (int i = 0; i < 7; i++) begin
            issue(vt[i]);
            tick();
            tick();
        end

        // Back-to-back B reads with req held high
        b_req = 1'b1; b_we = 1'b0; b_addr = 19'h00000;
        e.we = 1'b0; e.data = 8'h3C; qb.push_back(e);
        n = 0; first = -1; second = -1; seen_max = 1'b0;
        while (second < 0 && n < 40) begin
            tick();
            n++;
            if (sram_addr == 19'h7FFFF) seen_max = 1'b1;
            if (b_ack) begin
                if (first < 0) begin
                    first = n;
                    b_addr = 19'h7FFFF;
                    e.data = 8'hC3; qb.push_back(e);
                end else begin
                    second = n;
                    b_req = 1'b0;
                end
            end
        end
        b_req = 1'b0;
        chk("b2b_spacing", second - first, AC + 3);
        chk("b2b_addr_max", seen_max, 1);
        tick();
        tick();

        // Inputs change and req drops after the grant
        b_req = 1'b1; b_we = 1'b1; b_addr = 19'h0ABCD; b_wdata = 8'h5E;
        e.we = 1'b1; e.data = 8'h00; qb.push_back(e);
        tick();
        tick();
        b_req = 1'b0; b_addr = 19'h11111; b_wdata = 8'hFF;
        n = 0; got = 1'b0;
        while (!got && n < 10) begin
            chk("held_addr", sram_addr, 19'h0ABCD);
            chk("held_dq_o", sram_dq_o, 8'h5E);
            got = b_ack;
            tick();
            n++;
        end
        chk("held_ack_seen", got, 1);
        tick();
        chk("held_mem_written", mem[19'h0ABCD], 8'h5E);
        chk("held_mem_other", mem[19'h11111], 8'h00);

        // Reset in the second STROBE cycle of a write
        b_req = 1'b1; b_we = 1'b1; b_addr = 19'h00555; b_wdata = 8'h77;
        tick();
        tick();
        tick();
        chk("abort_we_low", sram_we_n, 0);
        abort = 1'b1;
        sys_rst_i = 1'b1;
        tick();
        chk("abort_we_n", sram_we_n, 1);
        chk("abort_oe", sram_dq_oe, 0);
        chk("abort_busy", busy, 0);
        chk("abort_b_ack", b_ack, 0);
        sys_rst_i = 1'b0;
        b_req = 1'b0;
        repeat (4) begin
            tick();
            chk("abort_no_ack", b_ack, 0);
        end
        abort = 1'b0;
        chk("abort_mem_kept", mem[19'h00555], 8'h11);

        // Contention: both request together, four reads each
        sys_rst_i = 1'b1;
        tick();
        sys_rst_i = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) ord[i] = -1;
        a_req = 1'b1; a_addr = 19'h00100;
        e.we = 1'b0; e.data = 8'h10; qa.push_back(e);
        b_req = 1'b1; b_we = 1'b0; b_addr = 19'h00200;
        e.data = 8'h20; qb.push_back(e);
        na = 0; nb = 0; no = 0; n = 0;
        while ((na < 4 || nb < 4) && n < 200) begin
            tick();
            n++;
            if (a_ack) begin
                if (no < 8) ord[no] = 0;
                no++;
                na++;
                if (na < 4) begin
                    a_addr = 19'(19'h00100 + na);
                    e.data = 8'(8'h10 + na); qa.push_back(e);
                end else a_req = 1'b0;
            end
            if (b_ack) begin
                if (no < 8) ord[no] = 1;
                no++;
                nb++;
                if (nb < 4) begin
                    b_addr = 19'(19'h00200 + nb);
                    e.data = 8'(8'h20 + nb); qb.push_back(e);
                end else b_req = 1'b0;
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
`ifdef SRAM_ARB_FAIR_EN
            exp_ord = i % 2;
`else
            exp_ord = (i < 4) ? 0 : 1;
`endif
            chk("grant_order", ord[i], exp_ord);
        end
        tick();
        tick();
        chk("scoreboard_drained", qa.size() + qb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

endmodule
